// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson phase decoder and its code LUT.
// Optional lap counter is enabled by defining JOHNSON_LAP_COUNT_EN.
package johnson_pkg;

  localparam int PHASE_W = 3;
  localparam int CNT_W   = 4;

  localparam logic [3:0] CODE_P0 = 4'b1000;
  localparam logic [3:0] CODE_P1 = 4'b1100;
  localparam logic [3:0] CODE_P2 = 4'b1110;
  localparam logic [3:0] CODE_P3 = 4'b1111;
  localparam logic [3:0] CODE_P4 = 4'b0111;
  localparam logic [3:0] CODE_P5 = 4'b0011;
  localparam logic [3:0] CODE_P6 = 4'b0001;
  localparam logic [3:0] CODE_P7 = 4'b0000;

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } state_t;

  function automatic logic [PHASE_W-1:0] succ(
    input logic [PHASE_W-1:0] p
  );
    return p + 1'b1;
  endfunction

endpackage

// File: rtl/johnson_code_lut.sv
// Combinational Johnson code to phase map.
// Also used by the fault monitor.
module johnson_code_lut
  import johnson_pkg::*;
(
  input  logic [3:0]         code,
  output logic [PHASE_W-1:0] phase,
  output logic               legal
);

  always_comb begin
    phase = '0;
    legal = 1'b1;
    unique case (code)
      CODE_P0: phase = 3'd0;
      CODE_P1: phase = 3'd1;
      CODE_P2: phase = 3'd2;
      CODE_P3: phase = 3'd3;
      CODE_P4: phase = 3'd4;
      CODE_P5: phase = 3'd5;
      CODE_P6: phase = 3'd6;
      CODE_P7: phase = 3'd7;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Tracks a 4-bit Johnson counter, decodes phase, flags faults.
// Lap counter present only when JOHNSON_LAP_COUNT_EN is defined.
module johnson_phase_decoder
  import johnson_pkg::*;
#(
  parameter int RELOCK_N = 2,
  parameter int LAP_W    = 8
) (
  input  logic               C,
  input  logic               CLR,
  input  logic               EN,
  input  logic [3:0]         D,
  input  logic               ERR_CLR,
  output logic [PHASE_W-1:0] PHASE,
  output logic [7:0]         ONEHOT,
  output logic               VALID,
  output logic               ERR,
  output logic               ERR_STICKY,
  output logic [LAP_W-1:0]   LAPS,
  output logic               LAP_TICK
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PHASE_W-1:0] ph_q;
  logic [7:0]         oh_q;
  logic               err_q, sticky_q;

  logic [PHASE_W-1:0] d_ph, exp_ph;
  logic               d_legal, inseq;
  logic               accept, fault;

  johnson_code_lut u_lut (
    .code  (D),
    .phase (d_ph),
    .legal (d_legal)
  );

  assign exp_ph = EN ? succ(ph_q) : ph_q;
  assign inseq  = d_legal && (d_ph == exp_ph);

  always_ff @(posedge C) begin
    if (CLR) begin
      state_q  <= SYNC;
      cnt_q    <= '0;
      ph_q     <= '0;
      oh_q     <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= fault;
      if (accept) begin
        ph_q <= d_ph;
        oh_q <= 8'b1 << d_ph;
      end
      if (fault)
        sticky_q <= 1'b1;
      else if (ERR_CLR)
        sticky_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    fault   = 1'b0;
    unique case (state_q)
      SYNC: begin
        if (!d_legal) begin
          cnt_d = '0;
        end else begin
          accept = 1'b1;
          // a zero count means no usable history yet
          cnt_d = (cnt_q != '0 && inseq)
                ? cnt_q + 1'b1
                : CNT_W'(1);
          if (cnt_d >= CNT_W'(RELOCK_N))
            state_d = TRACK;
        end
      end
      TRACK: begin
        if (inseq) begin
          accept = 1'b1;
        end else begin
          fault   = 1'b1;
          state_d = SYNC;
          accept  = d_legal;
          cnt_d   = d_legal ? CNT_W'(1) : '0;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_comb begin
    VALID      = (state_q == TRACK);
    PHASE      = ph_q;
    ONEHOT     = oh_q;
    ERR        = err_q;
    ERR_STICKY = sticky_q;
  end

`ifdef JOHNSON_LAP_COUNT_EN
  logic [LAP_W-1:0] laps_q;
  logic             tick_q;
  logic             wrap;

  assign wrap = (state_q == TRACK) && inseq && EN
             && (ph_q == PHASE_W'(7));

  always_ff @(posedge C) begin
    if (CLR) begin
      laps_q <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= wrap;
      if (wrap)
        laps_q <= laps_q + 1'b1;
    end
  end

  assign LAPS     = laps_q;
  assign LAP_TICK = tick_q;
`else
  assign LAPS     = '0;
  assign LAP_TICK = 1'b0;
`endif

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed plus random stimulus against a behavioural model.
// Lap expectations follow JOHNSON_LAP_COUNT_EN.
module tb_johnson_phase_decoder;

  localparam int RN = 2;
  localparam int LW = 2;

  logic          C = 1'b0;
  logic          CLR = 1'b1;
  logic          EN = 1'b0;
  logic [3:0]    D = 4'b0;
  logic          ERR_CLR = 1'b0;
  logic [2:0]    PHASE;
  logic [7:0]    ONEHOT;
  logic          VALID, ERR, ERR_STICKY, LAP_TICK;
  logic [LW-1:0] LAPS;

  johnson_phase_decoder #(.RELOCK_N(RN), .LAP_W(LW)) dut (
    .C(C), .CLR(CLR), .EN(EN), .D(D), .ERR_CLR(ERR_CLR),
    .PHASE(PHASE), .ONEHOT(ONEHOT), .VALID(VALID),
    .ERR(ERR), .ERR_STICKY(ERR_STICKY),
    .LAPS(LAPS), .LAP_TICK(LAP_TICK)
  );

  always #5 C = ~C;

  int n_chk = 0;
  int n_fail = 0;

  int code_tab[8] = '{8, 12, 14, 15, 7, 3, 1, 0};
  int bad_tab[8]  = '{2, 4, 5, 6, 9, 10, 11, 13};

  // model state
  bit m_trk, m_seen, m_err, m_sticky, m_tick;
  int m_cnt, m_ph, m_laps;
  int cph;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ph_of(input logic [3:0] d);
    for (int i = 0; i < 8; i++)
      if (code_tab[i] == int'(d)) return i;
    return -1;
  endfunction

  task automatic model(input bit clr, input bit en,
                       input logic [3:0] d, input bit ec);
    int p, e;
    bit ok;
    if (clr) begin
      m_trk = 0; m_seen = 0; m_err = 0; m_sticky = 0;
      m_tick = 0; m_cnt = 0; m_ph = 0; m_laps = 0;
      return;
    end
    p = ph_of(d);
    e = en ? (m_ph + 1) % 8 : m_ph;
    ok = (p >= 0) && (p == e);
    m_err = 0;
    m_tick = 0;
    if (!m_trk) begin
      if (p < 0) m_cnt = 0;
      else begin
        m_cnt = (m_cnt > 0 && ok) ? m_cnt + 1 : 1;
        m_ph = p; m_seen = 1;
        if (m_cnt >= RN) m_trk = 1;
      end
    end else if (ok) begin
      if (en && m_ph == 7) begin
        m_laps = (m_laps + 1) % (1 << LW);
        m_tick = 1;
      end
      m_ph = p;
    end else begin
      m_err = 1; m_trk = 0;
      if (p >= 0) begin m_ph = p; m_cnt = 1; end
      else m_cnt = 0;
    end
    if (m_err) m_sticky = 1;
    else if (ec) m_sticky = 0;
  endtask

  task automatic check_all();
    chk("phase", 32'(PHASE), 32'(m_ph));
    chk("onehot", 32'(ONEHOT), m_seen ? (32'd1 << m_ph) : 32'd0);
    chk("valid", 32'(VALID), 32'(m_trk));
    chk("err", 32'(ERR), 32'(m_err));
    chk("sticky", 32'(ERR_STICKY), 32'(m_sticky));
`ifdef JOHNSON_LAP_COUNT_EN
    chk("laps", 32'(LAPS), 32'(m_laps));
    chk("tick", 32'(LAP_TICK), 32'(m_tick));
`else
    chk("laps", 32'(LAPS), 32'd0);
    chk("tick", 32'(LAP_TICK), 32'd0);
`endif
  endtask

  task automatic step(input bit clr, input bit en,
                      input logic [3:0] d, input bit ec);
    @(negedge C);
    CLR = clr; EN = en; D = d; ERR_CLR = ec;
    @(posedge C);
    model(clr, en, d, ec);
    #1;
    check_all();
  endtask

  // follow the counter: advance and present the next code
  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      cph = (cph + 1) % 8;
      step(0, 1, 4'(code_tab[cph]), 0);
    end
  endtask

  initial begin
    // reset
    step(1, 0, 4'h5, 0);
    step(1, 1, 4'h5, 1);
    chk("rst_phase", 32'(PHASE), 32'd0);
    chk("rst_onehot", 32'(ONEHOT), 32'd0);
    chk("rst_valid", 32'(VALID), 32'd0);

    // lock from 1000
    cph = 7;
    adv(1);
    chk("lock1_valid", 32'(VALID), 32'd0);
    adv(1);
    chk("lock2_valid", 32'(VALID), 32'd1);
    chk("lock2_phase", 32'(PHASE), 32'd1);
    chk("lock2_onehot", 32'(ONEHOT), 32'h02);
    adv(2);

    // illegal code while locked at phase 3
    step(0, 1, 4'b1010, 0);
    chk("ill_err", 32'(ERR), 32'd1);
    chk("ill_sticky", 32'(ERR_STICKY), 32'd1);
    chk("ill_valid", 32'(VALID), 32'd0);
    chk("ill_phase", 32'(PHASE), 32'd3);
    adv(2);
    chk("relock_valid", 32'(VALID), 32'd1);

    // skip from phase 2 to 4
    adv(5);
    step(0, 1, 4'b0111, 0);
    chk("skip_err", 32'(ERR), 32'd1);
    chk("skip_phase", 32'(PHASE), 32'd4);
    cph = 4;
    adv(1);
    chk("skip_relock", 32'(VALID), 32'd1);

    // hold with EN=0, then change while EN=0
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 4'b0011, 0);
      chk("hold_err", 32'(ERR), 32'd0);
    end
    step(0, 0, 4'b0001, 0);
    chk("hold_viol_err", 32'(ERR), 32'd1);
    cph = 6;

    // four revolutions, LAP_W=2 wraps
    adv(33);
`ifdef JOHNSON_LAP_COUNT_EN
    chk("laps_wrap", 32'(LAPS), 32'd0);
`endif

    // ERR_CLR racing a fault, then alone
    step(0, 1, 4'b1001, 1);
    chk("race_sticky", 32'(ERR_STICKY), 32'd1);
    step(0, 0, 4'b1001, 1);
    chk("clr_sticky", 32'(ERR_STICKY), 32'd0);

    // CLR while locked at phase 5
    cph = 7;
    adv(6);
    chk("pre_clr_phase", 32'(PHASE), 32'd5);
    chk("pre_clr_valid", 32'(VALID), 32'd1);
    step(1, 1, 4'b0001, 0);
    chk("clr_valid", 32'(VALID), 32'd0);
    chk("clr_err", 32'(ERR), 32'd0);
    chk("clr_onehot", 32'(ONEHOT), 32'd0);
    cph = 7;

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      int r;
      bit en, ec;
      logic [3:0] d;
      r = $urandom_range(0, 99);
      en = 1'($urandom_range(0, 1));
      ec = ($urandom_range(0, 19) == 0);
      if (r < 1) begin
        cph = 7;
        step(1, en, 4'($urandom), ec);
        continue;
      end else if (r < 6) begin
        d = 4'(bad_tab[$urandom_range(0, 7)]);
      end else if (r < 10) begin
        cph = (cph + $urandom_range(2, 7)) % 8;
        d = 4'(code_tab[cph]);
      end else if (r < 13) begin
        en = 0;
        cph = (cph + $urandom_range(1, 7)) % 8;
        d = 4'(code_tab[cph]);
      end else begin
        if (en) cph = (cph + 1) % 8;
        d = 4'(code_tab[cph]);
      end
      step(0, en, d, ec);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
